// File: rtl/block_nconv_seq.sv
// Block sequencer: runs NUM_CONV 3x3 conv layers back-to-back, then an optional
// 2x2 max-pool + ReLU pass, with a per-stage watchdog and a saturating cycle counter.
module block_nconv_seq #(
  parameter int unsigned NUM_CONV          = 3,
  parameter int unsigned NUMBER_OF_CHANNEL = 3,
  parameter int unsigned NUMBER_OF_KERNEL  = 8,
  parameter int unsigned CH_WIDTH          = 10,
  parameter int unsigned POOL_EN           = 1,
  parameter int unsigned TIMEOUT_CYCLES    = 65535,
  parameter int unsigned CNT_WIDTH         = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic                 i_pool_bypass,
  input  logic                 i_conv_done,
  input  logic                 i_pool_done,
  output logic                 o_conv_start,
  output logic [2:0]           o_conv_layer,
  output logic [CH_WIDTH-1:0]  o_conv_channels,
  output logic                 o_pool_start,
  output logic                 o_busy,
  output logic                 o_valid,
  output logic                 o_error,
  output logic [CNT_WIDTH-1:0] o_cycle_count
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [2:0]      LAST_LAYER = 3'(NUM_CONV - 1);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, C_START, C_WAIT, P_START, P_WAIT, DONE, ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            layer_q, layer_d;
  logic [CH_WIDTH-1:0]   ch_q, ch_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  bypass_q, bypass_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  cstart_q, cstart_d;
  logic                  pstart_q, pstart_d;
  logic                  valid_q, valid_d;

  // Next-state and next-output logic; every output register is derived from state_d.
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    ch_d     = ch_q;
    wd_d     = wd_q;
    bypass_d = bypass_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    if (busy_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d  = C_START;
          bypass_d = i_pool_bypass;
          layer_d  = 3'd0;
          err_d    = 1'b0;
          cnt_d    = '0;
        end
      end
      C_START: begin
        wd_d    = '0;
        state_d = C_WAIT;
      end
      C_WAIT: begin
        if (i_conv_done) begin
          if (layer_q != LAST_LAYER) begin
            layer_d = layer_q + 3'd1;
            state_d = C_START;
          end else if ((POOL_EN != 0) && !bypass_q) begin
            state_d = P_START;
          end else begin
            state_d = DONE;
          end
        end else if (wd_q == WD_LAST) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      P_START: begin
        wd_d    = '0;
        state_d = P_WAIT;
      end
      P_WAIT: begin
        if (i_pool_done) begin
          state_d = DONE;
        end else if (wd_q == WD_LAST) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Layer 0 consumes the image channels; later layers consume the previous layer's kernels.
    if (state_d == C_START) begin
      ch_d = (layer_d == 3'd0) ? CH_WIDTH'(NUMBER_OF_CHANNEL) : CH_WIDTH'(NUMBER_OF_KERNEL);
    end

    cstart_d = (state_d == C_START);
    pstart_d = (state_d == P_START);
    valid_d  = (state_d == DONE);
    busy_d   = (state_d == C_START) || (state_d == C_WAIT) ||
               (state_d == P_START) || (state_d == P_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      layer_q  <= 3'd0;
      ch_q     <= '0;
      wd_q     <= '0;
      bypass_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      cstart_q <= 1'b0;
      pstart_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      ch_q     <= ch_d;
      wd_q     <= wd_d;
      bypass_q <= bypass_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      cstart_q <= cstart_d;
      pstart_q <= pstart_d;
      valid_q  <= valid_d;
    end
  end

  assign o_conv_start    = cstart_q;
  assign o_conv_layer    = layer_q;
  assign o_conv_channels = ch_q;
  assign o_pool_start    = pstart_q;
  assign o_busy          = busy_q;
  assign o_valid         = valid_q;
  assign o_error         = err_q;
  assign o_cycle_count   = cnt_q;

endmodule

// File: tb/tb_block_nconv_seq.sv
// Bench for block_nconv_seq: two configurations against a job-list model, with
// directed timing pins followed by randomized runs with spurious done pulses.
module tb_block_nconv_seq;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] vld, byp, cd, pd;

  logic       cs0, ps0, busy0, ov0, err0;
  logic [2:0] lay0;
  logic [9:0] ch0;
  logic [23:0] cnt0;
  logic       cs1, ps1, busy1, ov1, err1;
  logic [2:0] lay1;
  logic [9:0] ch1;
  logic [3:0] cnt1;

  always #5 clk = ~clk;

  block_nconv_seq #(
    .NUM_CONV(3), .NUMBER_OF_CHANNEL(3), .NUMBER_OF_KERNEL(8), .CH_WIDTH(10),
    .POOL_EN(1), .TIMEOUT_CYCLES(10), .CNT_WIDTH(24)
  ) u0 (
    .clk(clk), .rst(rst), .i_valid(vld[0]), .i_pool_bypass(byp[0]),
    .i_conv_done(cd[0]), .i_pool_done(pd[0]), .o_conv_start(cs0),
    .o_conv_layer(lay0), .o_conv_channels(ch0), .o_pool_start(ps0),
    .o_busy(busy0), .o_valid(ov0), .o_error(err0), .o_cycle_count(cnt0)
  );

  block_nconv_seq #(
    .NUM_CONV(1), .NUMBER_OF_CHANNEL(3), .NUMBER_OF_KERNEL(8), .CH_WIDTH(10),
    .POOL_EN(0), .TIMEOUT_CYCLES(20), .CNT_WIDTH(4)
  ) u1 (
    .clk(clk), .rst(rst), .i_valid(vld[1]), .i_pool_bypass(byp[1]),
    .i_conv_done(cd[1]), .i_pool_done(pd[1]), .o_conv_start(cs1),
    .o_conv_layer(lay1), .o_conv_channels(ch1), .o_pool_start(ps1),
    .o_busy(busy1), .o_valid(ov1), .o_error(err1), .o_cycle_count(cnt1)
  );

  // Per-instance configuration
  int p_nconv[2] = '{3, 1};
  int p_pool[2]  = '{1, 0};
  int p_to[2]    = '{10, 20};
  int p_cmax[2]  = '{16777215, 15};
  int p_nch      = 3;
  int p_nk       = 8;

  // Model: a run is a list of jobs (conv layers, then optional pool); each job
  // is one start cycle followed by waiting cycles.
  bit m_active[2];
  bit m_instart[2];
  int m_j[2];
  int m_njobs[2];
  int m_waited[2];
  int m_fin[2];     // 1 = completion cycle, 2 = error cycle
  int e_layer[2];
  int e_ch[2];
  int e_cnt[2];
  bit e_err[2];

  // Responder state
  int cdwn[2];
  bit cpool[2];
  int fixed_dly[2]; // 0 = random, -1 = never answer
  bit spur_en;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s u%0d: got %0d, expected %0d at t=%0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic bit exp_cs(input int k);
    return m_active[k] && m_instart[k] && (m_j[k] < p_nconv[k]);
  endfunction

  function automatic bit exp_ps(input int k);
    return m_active[k] && m_instart[k] && (m_j[k] >= p_nconv[k]);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 0; m_instart[k] = 0; m_j[k] = 0; m_njobs[k] = 0;
      m_waited[k] = 0; m_fin[k] = 0; e_layer[k] = 0; e_ch[k] = 0;
      e_cnt[k] = 0; e_err[k] = 0; cdwn[k] = -1; cpool[k] = 0;
    end
  endfunction

  function automatic void model_step(input int k, input bit v, input bit b, input bit c, input bit p);
    bit done;
    if (m_fin[k] != 0) begin
      m_fin[k] = 0;
      return;
    end
    if (!m_active[k]) begin
      if (v) begin
        m_active[k]  = 1;
        m_instart[k] = 1;
        m_j[k]       = 0;
        m_njobs[k]   = p_nconv[k] + ((p_pool[k] != 0 && !b) ? 1 : 0);
        e_err[k]     = 0;
        e_cnt[k]     = 0;
        e_layer[k]   = 0;
        e_ch[k]      = p_nch;
      end
      return;
    end
    if (e_cnt[k] < p_cmax[k]) e_cnt[k]++;
    if (m_instart[k]) begin
      m_instart[k] = 0;
      m_waited[k]  = 0;
      return;
    end
    done = (m_j[k] < p_nconv[k]) ? c : p;
    if (done) begin
      m_j[k]++;
      if (m_j[k] == m_njobs[k]) begin
        m_active[k] = 0;
        m_fin[k]    = 1;
      end else begin
        m_instart[k] = 1;
        if (m_j[k] < p_nconv[k]) begin
          e_layer[k] = m_j[k];
          e_ch[k]    = p_nk;
        end
      end
    end else if (m_waited[k] + 1 >= p_to[k]) begin
      m_active[k] = 0;
      m_fin[k]    = 2;
      e_err[k]    = 1;
    end else begin
      m_waited[k]++;
    end
  endfunction

  function automatic int pick_delay(input int k);
    if (fixed_dly[k] != 0) return fixed_dly[k];
    return (k == 0) ? int'($urandom_range(12, 1)) : int'($urandom_range(24, 1));
  endfunction

  // One cycle of stimulus: inputs applied after the falling edge, model advanced to the next cycle.
  task automatic cyc(input logic [1:0] v, input logic [1:0] b, input logic [1:0] xc, input logic [1:0] xp);
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      bit c, p;
      c = 0;
      p = 0;
      if (m_active[k] && m_instart[k]) begin
        cdwn[k]  = pick_delay(k);
        cpool[k] = (m_j[k] >= p_nconv[k]);
      end else if (cdwn[k] > 0) begin
        cdwn[k]--;
        if (cdwn[k] == 0) begin
          if (cpool[k]) p = 1; else c = 1;
        end
      end
      if (spur_en && $urandom_range(9) == 0) c = 1;
      if (spur_en && $urandom_range(9) == 0) p = 1;
      c = c | xc[k];
      p = p | xp[k];
      vld[k] = v[k];
      byp[k] = b[k];
      cd[k]  = c;
      pd[k]  = p;
      model_step(k, v[k], b[k], c, p);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    vld = '0; byp = '0; cd = '0; pd = '0;
    #1;
    chk("rst_ctrl", 0, int'({cs0, ps0, busy0, ov0, err0}), 0);
    chk("rst_data", 0, int'(lay0) + int'(ch0) + int'(cnt0), 0);
    chk("rst_ctrl", 1, int'({cs1, ps1, busy1, ov1, err1}), 0);
    chk("rst_data", 1, int'(lay1) + int'(ch1) + int'(cnt1), 0);
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("busy",   0, int'(busy0), int'(m_active[0]));
      chk("cstart", 0, int'(cs0),   int'(exp_cs(0)));
      chk("pstart", 0, int'(ps0),   int'(exp_ps(0)));
      chk("valid",  0, int'(ov0),   int'(m_fin[0] == 1));
      chk("error",  0, int'(err0),  int'(e_err[0]));
      chk("layer",  0, int'(lay0),  e_layer[0]);
      chk("chan",   0, int'(ch0),   e_ch[0]);
      chk("count",  0, int'(cnt0),  e_cnt[0]);
      chk("busy",   1, int'(busy1), int'(m_active[1]));
      chk("cstart", 1, int'(cs1),   int'(exp_cs(1)));
      chk("pstart", 1, int'(ps1),   int'(exp_ps(1)));
      chk("valid",  1, int'(ov1),   int'(m_fin[1] == 1));
      chk("error",  1, int'(err1),  int'(e_err[1]));
      chk("layer",  1, int'(lay1),  e_layer[1]);
      chk("chan",   1, int'(ch1),   e_ch[1]);
      chk("count",  1, int'(cnt1),  e_cnt[1]);
    end
  end

  initial begin
    int ncs, nps, nv;
    rst = 1'b1;
    vld = '0; byp = '0; cd = '0; pd = '0;
    spur_en = 0;
    fixed_dly[0] = 3;
    fixed_dly[1] = 3;
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Default run, done 3 cycles after every start
    cyc(2'b01, 2'b00, 2'b00, 2'b00);
    ncs = 0; nps = 0; nv = 0;
    for (int rel = 1; rel <= 20; rel++) begin
      ncs += int'(exp_cs(0)); nps += int'(exp_ps(0)); nv += int'(m_fin[0] == 1);
      if (rel == 1 || rel == 5 || rel == 9) begin
        chk("pin_cstart", 0, int'(exp_cs(0)), 1);
        chk("pin_chan", 0, e_ch[0], (rel == 1) ? 3 : 8);
      end
      if (rel == 13) chk("pin_pstart", 0, int'(exp_ps(0)), 1);
      if (rel == 17) begin
        chk("pin_valid", 0, int'(m_fin[0] == 1), 1);
        chk("pin_count", 0, e_cnt[0], 16);
      end
      cyc(2'b00, 2'b00, 2'b00, 2'b00);
    end
    chk("pin_ncstart", 0, ncs, 3);
    chk("pin_npstart", 0, nps, 1);
    chk("pin_nvalid", 0, nv, 1);

    // Pool bypass
    cyc(2'b01, 2'b01, 2'b00, 2'b00);
    nps = 0;
    for (int rel = 1; rel <= 16; rel++) begin
      nps += int'(exp_ps(0));
      if (rel == 13) begin
        chk("pin_byp_valid", 0, int'(m_fin[0] == 1), 1);
        chk("pin_byp_count", 0, e_cnt[0], 12);
      end
      cyc(2'b00, 2'b00, 2'b00, 2'b00);
    end
    chk("pin_byp_npstart", 0, nps, 0);

    // Watchdog: conv engine never answers
    fixed_dly[0] = -1;
    cyc(2'b01, 2'b00, 2'b00, 2'b00);
    nv = 0;
    for (int rel = 1; rel <= 13; rel++) begin
      nv += int'(m_fin[0] == 1);
      if (rel == 11) chk("pin_wd_busy", 0, int'(m_active[0]), 1);
      if (rel == 12) begin
        chk("pin_wd_err", 0, int'(e_err[0]), 1);
        chk("pin_wd_busy_lo", 0, int'(m_active[0]), 0);
      end
      cyc(2'b00, 2'b00, 2'b00, 2'b00);
    end
    chk("pin_wd_nvalid", 0, nv, 0);
    fixed_dly[0] = 3;
    cyc(2'b01, 2'b00, 2'b00, 2'b00);
    chk("pin_err_clear", 0, int'(e_err[0]), 0);
    repeat (20) cyc(2'b00, 2'b00, 2'b00, 2'b00);

    // Spurious done pulses and i_valid re-pulsed while busy / in the DONE cycle
    cyc(2'b01, 2'b00, 2'b00, 2'b00);
    for (int rel = 1; rel <= 19; rel++) begin
      logic [1:0] v, xc, xp;
      v  = (rel == 3 || rel == 7 || rel == 17) ? 2'b01 : 2'b00;
      xc = (rel == 1) ? 2'b01 : 2'b00;
      xp = (rel == 2) ? 2'b01 : 2'b00;
      if (rel == 3) chk("pin_spur_layer", 0, e_layer[0], 0);
      if (rel == 5) chk("pin_spur_layer1", 0, e_layer[0], 1);
      if (rel == 17) chk("pin_rep_count", 0, e_cnt[0], 16);
      if (rel == 18) chk("pin_rep_idle", 0, int'(m_active[0]), 0);
      cyc(v, 2'b00, xc, xp);
    end

    // Reset in the middle of C_WAIT
    cyc(2'b01, 2'b00, 2'b00, 2'b00);
    cyc(2'b00, 2'b00, 2'b00, 2'b00);
    cyc(2'b00, 2'b00, 2'b00, 2'b00);
    do_reset();
    repeat (3) cyc(2'b00, 2'b00, 2'b00, 2'b00);

    // Single conv layer, no pool stage
    cyc(2'b10, 2'b00, 2'b00, 2'b00);
    nps = 0;
    for (int rel = 1; rel <= 8; rel++) begin
      nps += int'(exp_ps(1));
      if (rel == 1) begin
        chk("pin_u1_cstart", 1, int'(exp_cs(1)), 1);
        chk("pin_u1_chan", 1, e_ch[1], 3);
      end
      if (rel == 5) begin
        chk("pin_u1_valid", 1, int'(m_fin[1] == 1), 1);
        chk("pin_u1_count", 1, e_cnt[1], 4);
      end
      cyc(2'b00, 2'b00, 2'b00, 2'b00);
    end
    chk("pin_u1_npstart", 1, nps, 0);

    // Long wait saturates the 4-bit counter
    fixed_dly[1] = 18;
    cyc(2'b10, 2'b00, 2'b00, 2'b00);
    for (int rel = 1; rel <= 22; rel++) begin
      if (rel == 20) begin
        chk("pin_sat_valid", 1, int'(m_fin[1] == 1), 1);
        chk("pin_sat_count", 1, e_cnt[1], 15);
      end
      cyc(2'b00, 2'b00, 2'b00, 2'b00);
    end

    // Randomized traffic on both instances
    fixed_dly[0] = 0;
    fixed_dly[1] = 0;
    spur_en = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 900 == 899) begin
        do_reset();
      end else begin
        logic [1:0] v, b;
        v[0] = ($urandom_range(5) == 0);
        v[1] = ($urandom_range(5) == 0);
        b    = 2'($urandom_range(3));
        cyc(v, b, 2'b00, 2'b00);
      end
    end
    repeat (2) cyc(2'b00, 2'b00, 2'b00, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/block_nconv_seq.md
Name: block_nconv_seq

Overview:
- Parametrised successor to the fixed three-conv VGG block: a sequencer that runs NUM_CONV 3x3 conv layers back-to-back on a conv engine, then optionally runs one 2x2 max-pool + ReLU pass.
- Issues per-layer start pulses and per-layer channel configuration, and waits for each stage's done handshake.
- Adds features the fixed block lacks: a runtime pool-bypass mode, a per-stage watchdog with an error exit, and a total-cycle performance counter.
- Sits between the VGG top-level controller and the conv/pool engines.

Parameters:
- NUM_CONV, 3, conv layers per block; legal range 1..8.
- NUMBER_OF_CHANNEL, 3, input channels of layer 0.
- NUMBER_OF_KERNEL, 8, kernels per layer; this is also the input channel count of layers 1..NUM_CONV-1.
- CH_WIDTH, 10, width of the channel-count output.
- POOL_EN, 1, 1 = pool stage present; 0 = pool never run.
- TIMEOUT_CYCLES, 65535, maximum wait cycles per stage before error.
- CNT_WIDTH, 24, width of the cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  start pulse for the block.
- i_pool_bypass  in  1  skip pooling for this run; sampled when i_valid is accepted.
- i_conv_done  in  1  conv engine finished the current layer; single-cycle pulse.
- i_pool_done  in  1  pool engine finished; single-cycle pulse.
- o_conv_start  out  1  one-cycle start pulse to the conv engine.
- o_conv_layer  out  3  index of the active conv layer, 0..NUM_CONV-1.
- o_conv_channels  out  CH_WIDTH  input channel count for the active layer.
- o_pool_start  out  1  one-cycle start pulse to the pool engine.
- o_busy  out  1  high from start acceptance until DONE or ERROR.
- o_valid  out  1  one-cycle block-complete pulse.
- o_error  out  1  sticky watchdog error flag.
- o_cycle_count  out  CNT_WIDTH  cycles spent in the last or current run; saturates at the maximum value.

Behaviour:
- Reset: all outputs 0, state IDLE, layer index 0, watchdog 0, bypass latch 0. Reset is asynchronous and valid mid-run: the FSM returns to IDLE immediately and no further pulses are issued.
- All outputs are registered.
- FSM states: IDLE, C_START, C_WAIT, P_START, P_WAIT, DONE, ERROR.
- IDLE:
  - i_valid=1 moves to C_START.
  - On that transition: latch i_pool_bypass, set layer=0, clear o_error and o_cycle_count, set o_busy=1.
- C_START:
  - o_conv_start=1 for exactly this one cycle.
  - o_conv_channels = NUMBER_OF_CHANNEL if layer==0, else NUMBER_OF_KERNEL.
  - Watchdog cleared. Next state C_WAIT.
- C_WAIT:
  - i_conv_done with layer<NUM_CONV-1: layer+1, go to C_START.
  - i_conv_done with layer==NUM_CONV-1: go to P_START if POOL_EN=1 and bypass latch=0, else go to DONE.
- Done-pulse filtering: i_conv_done arriving in any state other than C_WAIT is ignored, including the C_START cycle. The same applies to i_pool_done outside P_WAIT.
- P_START: o_pool_start=1 for one cycle, watchdog cleared, next state P_WAIT.
- P_WAIT: i_pool_done moves to DONE.
- Watchdog:
  - Counts each cycle spent in C_WAIT or P_WAIT.
  - When it reaches TIMEOUT_CYCLES with no done pulse, go to ERROR.
- DONE: o_valid=1 for one cycle, o_busy=0, next state IDLE.
- ERROR: o_error=1 and o_busy=0, next state IDLE. o_error stays high until the next accepted i_valid or reset. o_valid is not pulsed on error.
- i_valid while o_busy=1 is ignored; there is no queueing.
- i_valid in the DONE or ERROR cycle is ignored; it is accepted from the IDLE cycle onwards.
- o_cycle_count:
  - Increments every cycle that o_busy=1.
  - Holds its value after DONE or ERROR until the next start.
  - Saturates at 2^CNT_WIDTH-1 and never wraps.
- o_conv_layer and o_conv_channels hold their last values while in P_*, DONE and IDLE.
- Latency: i_valid to first o_conv_start is 1 cycle. Each done pulse to the next start pulse is 1 cycle. The last done to o_valid is 1 cycle.

Test Plan:
- Defaults, done pulses returned 3 cycles after each start:
  - o_conv_start at cycles 1, 5, 9; o_conv_channels = 3, 8, 8.
  - o_pool_start at cycle 13, o_valid at cycle 17, o_cycle_count=16.
- i_pool_bypass=1 at start, same conv timing: no o_pool_start; o_valid one cycle after the third i_conv_done.
- TIMEOUT_CYCLES=10, i_conv_done never asserted: ERROR entered after 10 C_WAIT cycles; o_error=1, o_busy=0, o_valid never pulses. The next i_valid clears o_error.
- Spurious pulses: i_conv_done during C_START and i_pool_done during C_WAIT are ignored; the layer index does not advance.
- i_valid re-pulsed while busy: no effect on layer index or cycle count. rst asserted mid-C_WAIT: all outputs are 0 in the same cycle and the FSM is in IDLE.
- NUM_CONV=1 with POOL_EN=0: a single conv with channels=3, then o_valid. CNT_WIDTH=4 with long done delays: o_cycle_count holds at 15.
